// File: rtl/sn_read_responder_pkg.sv
// Shared CHI definitions for the SN read responder: flit layouts, opcodes,
// response encodings, the request FIFO entry, FSM states and flit builders.
package sn_read_responder_pkg;

    localparam int CHI_ADDR_W   = 48;
    localparam int CHI_NID_W    = 7;
    localparam int CHI_TXNID_W  = 8;
    localparam int CHI_DATA_W   = 128;
    localparam int CHI_DATAID_W = 2;

    // REQ channel opcodes
    localparam logic [5:0] OP_READ_NO_SNP = 6'h04;
    localparam logic [5:0] OP_READ_UNIQUE = 6'h07;
    // DAT channel opcodes
    localparam logic [3:0] DAT_COMP_DATA  = 4'h4;
    // Response state encodings
    localparam logic [2:0] CHI_RESP_UC    = 3'b010;

    typedef struct packed {
        logic [CHI_NID_W-1:0]   tgt_id;
        logic [CHI_NID_W-1:0]   src_id;
        logic [CHI_TXNID_W-1:0] txn_id;
        logic [CHI_NID_W-1:0]   return_nid;
        logic [CHI_TXNID_W-1:0] return_txn_id;
        logic [5:0]             opcode;
        logic [2:0]             size;
        logic [CHI_ADDR_W-1:0]  addr;
    } reqflit_t;

    typedef struct packed {
        logic [CHI_NID_W-1:0]    tgt_id;
        logic [CHI_NID_W-1:0]    src_id;
        logic [CHI_TXNID_W-1:0]  txn_id;
        logic [CHI_NID_W-1:0]    home_nid;
        logic [3:0]              opcode;
        logic [1:0]              resp_err;
        logic [2:0]              resp;
        logic [CHI_TXNID_W-1:0]  dbid;
        logic [CHI_DATAID_W-1:0] data_id;
        logic [CHI_DATA_W-1:0]   data;
    } datflit_t;

    // What the responder keeps of an accepted ReadNoSnp.
    typedef struct packed {
        logic [CHI_ADDR_W-1:0]  addr;
        logic [2:0]             size;
        logic [CHI_NID_W-1:0]   src_id;
        logic [CHI_TXNID_W-1:0] txn_id;
        logic [CHI_NID_W-1:0]   return_nid;
        logic [CHI_TXNID_W-1:0] return_txn_id;
    } req_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    function automatic reqflit_t create_read_no_snp_req_flit(
        input logic [CHI_NID_W-1:0]   tgt_id,
        input logic [CHI_NID_W-1:0]   src_id,
        input logic [CHI_TXNID_W-1:0] txn_id,
        input logic [CHI_NID_W-1:0]   return_nid,
        input logic [CHI_TXNID_W-1:0] return_txn_id,
        input logic [2:0]             size,
        input logic [CHI_ADDR_W-1:0]  addr
    );
        reqflit_t f;
        f.tgt_id        = tgt_id;
        f.src_id        = src_id;
        f.txn_id        = txn_id;
        f.return_nid    = return_nid;
        f.return_txn_id = return_txn_id;
        f.opcode        = OP_READ_NO_SNP;
        f.size          = size;
        f.addr          = addr;
        return f;
    endfunction

    function automatic datflit_t create_comp_data_flit(
        input logic [CHI_NID_W-1:0]    tgt_id,
        input logic [CHI_TXNID_W-1:0]  txn_id,
        input logic [CHI_NID_W-1:0]    src_id,
        input logic [CHI_NID_W-1:0]    home_nid,
        input logic [CHI_TXNID_W-1:0]  dbid,
        input logic [CHI_DATAID_W-1:0] data_id,
        input logic [2:0]              resp,
        input logic [CHI_DATA_W-1:0]   data
    );
        datflit_t f;
        f.tgt_id   = tgt_id;
        f.src_id   = src_id;
        f.txn_id   = txn_id;
        f.home_nid = home_nid;
        f.opcode   = DAT_COMP_DATA;
        f.resp_err = 2'b00;
        f.resp     = resp;
        f.dbid     = dbid;
        f.data_id  = data_id;
        f.data     = data;
        return f;
    endfunction

endpackage

// File: rtl/sn_req_fifo.sv
// Synchronous FIFO holding accepted read requests. Pointers carry one extra
// bit so that full and empty are distinguishable without a counter.
module sn_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   store_q [DEPTH];
    logic           do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = store_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointer values; push while full and pop while empty are ignored.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    // Entry storage; stale contents are masked by the empty flag.
    always_ff @(posedge clock) begin
        if (do_push) store_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/sn_read_responder.sv
// SN-F read responder: queues ReadNoSnp requests, waits a fixed memory
// latency, snapshots the addressed line and streams CompData beats.
// Handshake: a flit moves on a channel in any cycle where valid and ready
// are both high at the rising clock edge; a presented DAT flit is held
// unchanged until it is taken.
module sn_read_responder
    import sn_read_responder_pkg::*;
#(
    parameter int         ADDR_W     = CHI_ADDR_W,
    parameter int         DATA_W     = CHI_DATA_W,
    parameter int         LINE_BYTES = 64,
    parameter int         MEM_LINES  = 256,
    parameter int         REQ_DEPTH  = 4,
    parameter int         READ_LAT   = 8,
    parameter logic [6:0] NODE_ID    = 7'h20
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      rxreq_valid,
    output logic                                      rxreq_ready,
    input  reqflit_t                                  rxreqflit,
    output logic                                      txdat_valid,
    input  logic                                      txdat_ready,
    output datflit_t                                  txdatflit,
    input  logic                                      mem_wr_en,
    input  logic [$clog2(MEM_LINES)-1:0]              mem_wr_line,
    input  logic [$clog2(LINE_BYTES*8/DATA_W)-1:0]    mem_wr_beat,
    input  logic [DATA_W-1:0]                         mem_wr_data,
    output logic                                      err_unsupported,
    output state_e                                    dbg_state
);
    localparam int BEATS    = LINE_BYTES * 8 / DATA_W;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int LINE_W   = $clog2(MEM_LINES);
    localparam int LINE_LSB = $clog2(LINE_BYTES);
    localparam int BEAT_LSB = $clog2(DATA_W / 8);
    localparam int LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] last_q, last_d;
    req_entry_t        entry_q, entry_d;
    logic [DATA_W-1:0] line_q [BEATS];
    logic [DATA_W-1:0] line_d [BEATS];
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [MEM_LINES][BEATS];

    logic              req_fire, fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_entry_t        push_entry, fifo_head;
    logic              snap;
    logic [ADDR_W-1:0] snap_addr;
    logic [LINE_W-1:0] snap_line;
    logic [BEAT_W-1:0] head_off;
    logic              unused_fields;

    assign req_fire  = rxreq_valid && rxreq_ready;
    assign fifo_push = req_fire && (rxreqflit.opcode == OP_READ_NO_SNP);
    assign push_entry = '{addr:          rxreqflit.addr,
                          size:          rxreqflit.size,
                          src_id:        rxreqflit.src_id,
                          txn_id:        rxreqflit.txn_id,
                          return_nid:    rxreqflit.return_nid,
                          return_txn_id: rxreqflit.return_txn_id};
    assign err_unsupported = err_q;
    assign dbg_state       = state_q;
    assign unused_fields   = ^{rxreqflit, entry_q, fifo_head};

    sn_req_fifo #(
        .W     ($bits(req_entry_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Backdoor preload port; memory contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_wr_en) mem_q[mem_wr_line][mem_wr_beat] <= mem_wr_data;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = (READ_LAT == 0) ? ST_SEND : ST_WAIT;
            ST_WAIT: if (lat_q == LAT_W'(1)) state_d = ST_SEND;
            ST_SEND: if (txdat_ready && (beat_q == last_q)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, request backpressure and the DAT flit.
    always_comb begin
        fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
        rxreq_ready = !fifo_full;
        txdat_valid = (state_q == ST_SEND);
        txdatflit   = '0;
        if (state_q == ST_SEND) begin
            txdatflit = create_comp_data_flit(entry_q.return_nid, entry_q.return_txn_id,
                                              NODE_ID, entry_q.src_id, entry_q.txn_id,
                                              beat_q, CHI_RESP_UC, line_q[beat_q]);
        end
    end

    // Working registers: request capture, latency count, beat window, line snapshot.
    always_comb begin
        entry_d   = entry_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        last_d    = last_q;
        line_d    = line_q;
        err_d     = err_q | (req_fire && (rxreqflit.opcode != OP_READ_NO_SNP));
        snap      = 1'b0;
        snap_addr = entry_q.addr;
        head_off  = fifo_head.addr[BEAT_LSB +: BEAT_W];
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    entry_d = fifo_head;
                    lat_d   = LAT_W'(READ_LAT);
                    // Size 4 and below fits one beat; 5 is an aligned half line.
                    if (fifo_head.size <= 3'd4) begin
                        beat_d = head_off;
                        last_d = head_off;
                    end else if (fifo_head.size == 3'd5) begin
                        beat_d = {head_off[BEAT_W-1], {(BEAT_W-1){1'b0}}};
                        last_d = {head_off[BEAT_W-1], {(BEAT_W-1){1'b1}}};
                    end else begin
                        beat_d = '0;
                        last_d = '1;
                    end
                    // With no latency the snapshot has to come from the head itself.
                    if (READ_LAT == 0) begin
                        snap      = 1'b1;
                        snap_addr = fifo_head.addr;
                    end
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) snap = 1'b1;
            end
            ST_SEND: begin
                if (txdat_ready) beat_d = beat_q + BEAT_W'(1);
            end
            default: ;
        endcase
        snap_line = snap_addr[LINE_LSB +: LINE_W];
        if (snap) begin
            for (int b = 0; b < BEATS; b++) line_d[b] = mem_q[snap_line][b];
        end
    end

    // Working register flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry_q <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            line_q  <= '{default: '0};
            err_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sn_read_responder.sv
// Bench for sn_read_responder: directed scenarios plus a randomized phase,
// responses checked against a line-level memory model through an
// expected-flit queue drained by an independent monitor.
module tb_sn_read_responder;
    import sn_read_responder_pkg::*;

    localparam int READ_LAT = 8;
    localparam int FW       = $bits(datflit_t);

    logic       clock;
    logic       reset;
    logic       rxreq_valid;
    logic       rxreq_ready;
    reqflit_t   rxreqflit;
    logic       txdat_valid;
    logic       txdat_ready;
    datflit_t   txdatflit;
    logic       mem_wr_en;
    logic [7:0] mem_wr_line;
    logic [1:0] mem_wr_beat;
    logic [127:0] mem_wr_data;
    logic       err_unsupported;
    state_e     dbg_state;

    sn_read_responder #(
        .READ_LAT (READ_LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rxreq_valid     (rxreq_valid),
        .rxreq_ready     (rxreq_ready),
        .rxreqflit       (rxreqflit),
        .txdat_valid     (txdat_valid),
        .txdat_ready     (txdat_ready),
        .txdatflit       (txdatflit),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_line     (mem_wr_line),
        .mem_wr_beat     (mem_wr_beat),
        .mem_wr_data     (mem_wr_data),
        .err_unsupported (err_unsupported),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state / model ----------------
    logic [FW-1:0] exp_q[$];
    logic [127:0]  model_mem [256][4];
    int            acc_cyc;
    int            rise_cyc;
    int            hs_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected CompData beats for a ReadNoSnp, from the line/size rules.
    task automatic model_push(input logic [47:0] addr, input logic [2:0] size,
                              input logic [6:0] src, input logic [7:0] txn,
                              input logic [6:0] rnid, input logic [7:0] rtxn);
        int line, off, first, n;
        datflit_t f;
        line = int'(addr[13:6]);
        off  = int'(addr[5:4]);
        if (size <= 3'd4) begin first = off;           n = 1; end
        else if (size == 3'd5) begin first = (off / 2) * 2; n = 2; end
        else begin first = 0;                           n = 4; end
        for (int i = 0; i < n; i++) begin
            f          = '0;
            f.tgt_id   = rnid;
            f.src_id   = 7'h20;
            f.txn_id   = rtxn;
            f.home_nid = src;
            f.opcode   = 4'h4;
            f.resp_err = 2'b00;
            f.resp     = 3'b010;
            f.dbid     = txn;
            f.data_id  = 2'(first + i);
            f.data     = model_mem[line][first + i];
            exp_q.push_back(f);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [5:0] op, input logic [47:0] addr, input logic [2:0] size,
                            input logic [6:0] src, input logic [7:0] txn,
                            input logic [6:0] rnid, input logic [7:0] rtxn);
        bit got;
        rxreqflit               = '0;
        rxreqflit.tgt_id        = 7'h10;
        rxreqflit.src_id        = src;
        rxreqflit.txn_id        = txn;
        rxreqflit.return_nid    = rnid;
        rxreqflit.return_txn_id = rtxn;
        rxreqflit.opcode        = op;
        rxreqflit.size          = size;
        rxreqflit.addr          = addr;
        rxreq_valid             = 1'b1;
        got = 1'b0;
        for (int b = 0; b < 500 && !got; b++) begin
            @(negedge clock);
            if (rxreq_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
            end
            tick();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: addr %0h not accepted in 500 cycles", addr);
        end else if (op == 6'h04) begin
            model_push(addr, size, src, txn, rnid, rtxn);
        end
    endtask

    task automatic bd_write(input logic [7:0] line, input logic [1:0] beat, input logic [127:0] data);
        mem_wr_en   = 1'b1;
        mem_wr_line = line;
        mem_wr_beat = beat;
        mem_wr_data = data;
        tick();
        mem_wr_en = 1'b0;
        model_mem[line][beat] = data;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int b = 0; b < budget && !done; b++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !txdat_valid) done = 1'b1;
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: %0d expected beats still outstanding", exp_q.size());
        end
    endtask

    task automatic wait_valid(input int budget);
        bit done;
        done = 1'b0;
        for (int b = 0; b < budget && !done; b++) begin
            @(negedge clock);
            if (txdat_valid) done = 1'b1;
            tick();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: txdat_valid not seen in %0d cycles", budget);
        end
    endtask

    // ---------------- monitor ----------------
    logic     prev_valid = 1'b0;
    logic     stalled    = 1'b0;
    datflit_t held;

    always @(negedge clock) begin
        logic [FW-1:0] e;
        if (reset) begin
            stalled    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (stalled) begin
                n_checks++;
                if (!txdat_valid || txdatflit !== held) begin
                    n_fail++;
                    $display("FAIL dat_hold: valid=%0b flit=%h held=%h", txdat_valid, txdatflit, held);
                end
            end
            if (txdat_valid && !prev_valid) rise_cyc = cyc;
            if (txdat_valid && txdat_ready) begin
                hs_count++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dat_unexpected: got %h with nothing expected", txdatflit);
                end else begin
                    e = exp_q.pop_front();
                    if (txdatflit !== e) begin
                        n_fail++;
                        $display("FAIL dat_flit: got %h expected %h", txdatflit, e);
                    end
                end
                stalled = 1'b0;
            end else if (txdat_valid) begin
                stalled = 1'b1;
                held    = txdatflit;
            end else begin
                stalled = 1'b0;
            end
            prev_valid = txdat_valid;
        end
    end

    // ---------------- main sequence ----------------
    bit rand_on;

    initial begin
        int hs0, start_cyc;
        logic [63:0] r64;

        reset       = 1'b1;
        rxreq_valid = 1'b0;
        rxreqflit   = '0;
        txdat_ready = 1'b1;
        mem_wr_en   = 1'b0;
        mem_wr_line = '0;
        mem_wr_beat = '0;
        mem_wr_data = '0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;

        // Outputs coming out of reset
        @(negedge clock);
        chk("reset_rxreq_ready", 64'(rxreq_ready), 64'd1);
        chk("reset_txdat_valid", 64'(txdat_valid), 64'd0);
        chk("reset_txdatflit_zero", 64'(txdatflit == '0), 64'd1);
        chk("reset_err", 64'(err_unsupported), 64'd0);
        tick();

        // Random preload of the whole memory, then the known line 3
        for (int l = 0; l < 256; l++)
            for (int b = 0; b < 4; b++)
                bd_write(8'(l), 2'(b), {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int b = 0; b < 4; b++) bd_write(8'd3, 2'(b), 128'hA0 + 128'(b));

        // Full-line read and first-beat latency
        send_req(6'h04, 48'h0C0, 3'd6, 7'h01, 8'h15, 7'h05, 8'h22);
        rxreq_valid = 1'b0;
        wait_idle(200);
        chk("first_beat_latency", 64'(rise_cyc - acc_cyc), 64'(2 + READ_LAT));

        // Partial reads: single beat, half line, size 7 treated as full line
        send_req(6'h04, 48'h0E0, 3'd4, 7'h02, 8'h31, 7'h06, 8'h41);
        rxreq_valid = 1'b0;
        wait_idle(200);
        send_req(6'h04, 48'h0F0, 3'd5, 7'h03, 8'h32, 7'h07, 8'h42);
        rxreq_valid = 1'b0;
        wait_idle(200);
        send_req(6'h04, 48'h0D0, 3'd7, 7'h04, 8'h33, 7'h08, 8'h43);
        rxreq_valid = 1'b0;
        wait_idle(200);

        // Mid-line stall of 5 cycles
        txdat_ready = 1'b0;
        send_req(6'h04, 48'h0C0, 3'd6, 7'h09, 8'h50, 7'h0A, 8'h60);
        rxreq_valid = 1'b0;
        wait_valid(100);
        hs0 = hs_count;
        txdat_ready = 1'b1;
        tick();
        tick();
        txdat_ready = 1'b0;
        repeat (5) tick();
        txdat_ready = 1'b1;
        wait_idle(200);
        chk("stall_handshakes", 64'(hs_count - hs0), 64'd4);

        // Back-to-back requests with DAT blocked: 5 accepted, 6th waits
        txdat_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_req(6'h04, 48'h1000 + 48'(i * 64), 3'd6, 7'h11, 8'(8'h70 + i), 7'h12, 8'(8'h80 + i));
        @(negedge clock);
        chk("fifo_full_backpressure", 64'(rxreq_ready), 64'd0);
        tick();
        start_cyc = cyc;
        fork
            send_req(6'h04, 48'h2000, 3'd4, 7'h11, 8'h75, 7'h12, 8'h85);
            begin
                repeat (10) tick();
                txdat_ready = 1'b1;
            end
        join
        rxreq_valid = 1'b0;
        chk("sixth_req_blocked", 64'((acc_cyc - start_cyc) >= 10), 64'd1);
        wait_idle(500);

        // Unsupported opcode: consumed, no data, sticky error
        send_req(6'h07, 48'h0C0, 3'd6, 7'h01, 8'h90, 7'h05, 8'hA0);
        rxreq_valid = 1'b0;
        @(negedge clock);
        chk("err_set", 64'(err_unsupported), 64'd1);
        tick();
        repeat (30) tick();
        @(negedge clock);
        chk("err_sticky", 64'(err_unsupported), 64'd1);
        chk("ready_after_unsupported", 64'(rxreq_ready), 64'd1);
        tick();

        // Backdoor write during SEND is not seen by the in-flight response
        txdat_ready = 1'b0;
        send_req(6'h04, 48'h0C0, 3'd6, 7'h01, 8'h91, 7'h05, 8'hA1);
        rxreq_valid = 1'b0;
        wait_valid(100);
        bd_write(8'd3, 2'd0, 128'hB0);
        bd_write(8'd3, 2'd2, 128'hB2);
        txdat_ready = 1'b1;
        wait_idle(200);
        // Later read sees the new data
        send_req(6'h04, 48'h0C0, 3'd6, 7'h01, 8'h92, 7'h05, 8'hA2);
        rxreq_valid = 1'b0;
        wait_idle(200);
        bd_write(8'd3, 2'd0, 128'hA0);
        bd_write(8'd3, 2'd2, 128'hA2);

        // Reset during beat 2 with more requests queued
        txdat_ready = 1'b0;
        send_req(6'h04, 48'h0C0, 3'd6, 7'h01, 8'h93, 7'h05, 8'hA3);
        send_req(6'h04, 48'h3000, 3'd6, 7'h01, 8'h94, 7'h05, 8'hA4);
        send_req(6'h04, 48'h3040, 3'd4, 7'h01, 8'h95, 7'h05, 8'hA5);
        rxreq_valid = 1'b0;
        wait_valid(100);
        txdat_ready = 1'b1;
        tick();
        tick();
        txdat_ready = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clock);
        chk("reset_mid_valid_drop", 64'(txdat_valid), 64'd0);
        chk("reset_mid_rxreq_ready", 64'(rxreq_ready), 64'd1);
        tick();
        reset = 1'b0;
        txdat_ready = 1'b1;
        repeat (40) tick();
        @(negedge clock);
        chk("reset_clears_err", 64'(err_unsupported), 64'd0);
        tick();
        send_req(6'h04, 48'h0C0, 3'd6, 7'h01, 8'h96, 7'h05, 8'hA6);
        rxreq_valid = 1'b0;
        wait_idle(200);

        // Randomized requests with random DAT backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    r64 = {$urandom(), $urandom()};
                    send_req(6'h04, r64[47:0], 3'($urandom_range(0, 7)),
                             7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                             7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
                    if ($urandom_range(0, 3) == 0) begin
                        rxreq_valid = 1'b0;
                        tick();
                    end
                end
                rxreq_valid = 1'b0;
                wait_idle(5000);
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    tick();
                    txdat_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        txdat_ready = 1'b1;
        repeat (5) tick();

        chk("no_outstanding_beats", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
